gfx_reg_arbiter: RTL

GFX_REG_ARBITER -- requirements
Module: gfx_reg_arbiter

---
 rtl/gfx_reg_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gfx_reg_arbiter.sv
// Two-requester round-robin arbiter for a shared graphics register bus.
// Writes can be held off until vertical blanking; reads are never gated.
module gfx_reg_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned VBLANK_ONLY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        req0,
  input  logic        rd0,
  input  logic [3:0]  addr0,
  input  logic [15:0] wdata0,
  output logic        gnt0,
  output logic        done0,
  input  logic        req1,
  input  logic        rd1,
  input  logic [3:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        gnt1,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        gfx_cs,
  output logic        gfx_read,
  output logic [3:0]  gfx_addr,
  output logic [15:0] gfx_wdata,
  output logic        gfx_oe,
  input  logic [15:0] gfx_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        rd_q, rd_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic ungated;
  logic elig0, elig1, pick1;

  assign ungated = (VBLANK_ONLY == 0) | vblank;
  assign elig0   = req0 & (rd0 | ungated);
  assign elig1   = req1 & (rd1 | ungated);
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1   = elig1 & (~elig0 | ~last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          owner_d = pick1;
          last_d  = pick1;
          rd_d    = pick1 ? rd1 : rd0;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          cnt_d   = 4'(ACCESS_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = DONE;
          if (rd_q) rdata_d = gfx_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  logic busy, in_access, in_done;
  assign busy      = (state_q != IDLE);
  assign in_access = (state_q == ACCESS);
  assign in_done   = (state_q == DONE);

  assign gnt0      = busy & ~owner_q;
  assign gnt1      = busy & owner_q;
  assign done0     = in_done & ~owner_q;
  assign done1     = in_done & owner_q;
  assign rdata     = rdata_q;
  assign gfx_cs    = in_access;
  assign gfx_read  = in_access & rd_q;
  assign gfx_oe    = in_access & ~rd_q;
  assign gfx_addr  = in_access ? addr_q : '0;
  assign gfx_wdata = in_access ? wdata_q : '0;

endmodule
